// File: rtl/banco_registros_pipeline.sv
// Register file with a pending-result scoreboard: two registered read ports, one write port.
// Latency: reads return one cycle after read_enable; busy_1/busy_2 are combinational.
// Backpressure: none inside the block. The caller watches busy_x and stalls; reads are never gated.
module banco_registros_pipeline #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_address_1,
  input  logic [ADDR_W-1:0] read_address_2,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] data_write,
  input  logic              write_enable,
  input  logic              reserve_enable,
  input  logic [ADDR_W-1:0] reserve_address,
  output logic [DATA_W-1:0] data_register_1,
  output logic [DATA_W-1:0] data_register_2,
  output logic              read_valid,
  output logic              busy_1,
  output logic              busy_2
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  // Storage and pipeline registers.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0] data_1_q, data_1_d;
  logic [DATA_W-1:0] data_2_q, data_2_d;
  logic              valid_q, valid_d;

  // Decoded controls.
  logic              wr_to_zero;
  logic              wr_commit;
  logic              rsv_commit;
  logic [DATA_W-1:0] rd_val_1;
  logic [DATA_W-1:0] rd_val_2;

  // A write to register 0 is dropped when it is hardwired; same for a reserve of register 0.
  assign wr_to_zero = ZERO_EN && (write_address == '0);
  assign wr_commit  = write_enable && !wr_to_zero;
  assign rsv_commit = reserve_enable && !(ZERO_EN && (reserve_address == '0));

  // Read port 1 mux: stored value, bypassed by a same-cycle committed write, forced to zero for r0.
  always_comb begin
    rd_val_1 = mem_q[read_address_1];
    if (wr_commit && (write_address == read_address_1)) begin
      rd_val_1 = data_write;
    end
    if (ZERO_EN && (read_address_1 == '0)) begin
      rd_val_1 = '0;
    end
  end

  // Read port 2 mux: identical to port 1 but fully independent.
  always_comb begin
    rd_val_2 = mem_q[read_address_2];
    if (wr_commit && (write_address == read_address_2)) begin
      rd_val_2 = data_write;
    end
    if (ZERO_EN && (read_address_2 == '0)) begin
      rd_val_2 = '0;
    end
  end

  // Read pipeline next state: capture on read_enable, otherwise hold data and drop valid.
  always_comb begin
    data_1_d = data_1_q;
    data_2_d = data_2_q;
    valid_d  = read_enable;
    if (read_enable) begin
      data_1_d = rd_val_1;
      data_2_d = rd_val_2;
    end
  end

  // Memory next state: one committed write per cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_commit) begin
      mem_d[write_address] = data_write;
    end
  end

  // Scoreboard next state: the write clears first so a simultaneous reserve of the same
  // register wins and leaves it pending.
  always_comb begin
    pending_d = pending_q;
    if (write_enable) begin
      pending_d[write_address] = 1'b0;
    end
    if (rsv_commit) begin
      pending_d[reserve_address] = 1'b1;
    end
  end

  // Memory array: cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Scoreboard and read pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      data_1_q  <= '0;
      data_2_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      data_1_q  <= data_1_d;
      data_2_q  <= data_2_d;
      valid_q   <= valid_d;
    end
  end

  // A write landing this cycle resolves the hazard through the bypass path.
  assign busy_1 = pending_q[read_address_1] && !(write_enable && (write_address == read_address_1));
  assign busy_2 = pending_q[read_address_2] && !(write_enable && (write_address == read_address_2));

  assign data_register_1 = data_1_q;
  assign data_register_2 = data_2_q;
  assign read_valid      = valid_q;

endmodule

// File: tb/tb_banco_registros_pipeline.sv
module tb_banco_registros_pipeline;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] read_address_1, read_address_2, write_address, reserve_address;
  logic          read_enable, write_enable, reserve_enable;
  logic [DW-1:0] data_write;
  logic [DW-1:0] data_register_1, data_register_2;
  logic          read_valid, busy_1, busy_2;

  int n_pass = 0;
  int n_tot  = 0;

  banco_registros_pipeline #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .read_address_1  (read_address_1),
    .read_address_2  (read_address_2),
    .read_enable     (read_enable),
    .write_address   (write_address),
    .data_write      (data_write),
    .write_enable    (write_enable),
    .reserve_enable  (reserve_enable),
    .reserve_address (reserve_address),
    .data_register_1 (data_register_1),
    .data_register_2 (data_register_2),
    .read_valid      (read_valid),
    .busy_1          (busy_1),
    .busy_2          (busy_2)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state of the register file.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  logic [DW-1:0] m_d1, m_d2;
  bit            m_v;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_d1 = '0;
    m_d2 = '0;
    m_v  = 1'b0;
  endfunction

  // Architectural value seen by a read of address a during the current cycle.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (write_enable && write_address == a) return data_write;
    return m_mem[a];
  endfunction

  function automatic bit model_busy(input logic [AW-1:0] a);
    return m_pend[a] && !(write_enable && write_address == a);
  endfunction

  function automatic void model_step();
    if (read_enable) begin
      m_d1 = model_read(read_address_1);
      m_d2 = model_read(read_address_2);
    end
    m_v = read_enable;
    if (write_enable && write_address != 0) m_mem[write_address] = data_write;
    if (write_enable) m_pend[write_address] = 1'b0;
    if (reserve_enable && reserve_address != 0) m_pend[reserve_address] = 1'b1;
  endfunction

  // Compare process: check every cycle mid-period, advance the model at each rising edge.
  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) model_clear();
      chk("data_register_1", data_register_1, m_d1);
      chk("data_register_2", data_register_2, m_d2);
      chk("read_valid", {31'b0, read_valid}, {31'b0, m_v});
      chk("busy_1", {31'b0, busy_1}, {31'b0, model_busy(read_address_1)});
      chk("busy_2", {31'b0, busy_2}, {31'b0, model_busy(read_address_2)});
      @(posedge clk);
      if (!rst_n) model_clear();
      else model_step();
    end
  end

  task automatic set_in(input bit re, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit rv, input logic [AW-1:0] ra);
    read_enable     = re;
    read_address_1  = a1;
    read_address_2  = a2;
    write_enable    = we;
    write_address   = wa;
    data_write      = wd;
    reserve_enable  = rv;
    reserve_address = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fresh reset: reads of 7 and 31 return zero with valid one cycle later.
    set_in(1, 7, 31, 0, 0, 0, 0, 0);
    tick();
    chk("lit_reset_valid", {31'b0, read_valid}, 32'd1);
    chk("lit_reset_d1", data_register_1, 32'h0);
    chk("lit_reset_d2", data_register_2, 32'h0);

    // Write then read back.
    set_in(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    tick();
    set_in(1, 5, 0, 0, 0, 0, 0, 0);
    tick();
    chk("lit_wr_rd_d1", data_register_1, 32'hDEADBEEF);

    // Same-cycle bypass on both ports.
    set_in(1, 9, 9, 1, 9, 32'h12345678, 0, 0);
    tick();
    chk("lit_bypass_d1", data_register_1, 32'h12345678);
    chk("lit_bypass_d2", data_register_2, 32'h12345678);

    // Hardwired zero register, including reserve attempts.
    set_in(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("lit_zero_busy_same", {31'b0, busy_1}, 32'd0);
    tick();
    chk("lit_zero_rd", data_register_1, 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lit_zero_busy_after", {31'b0, busy_1}, 32'd0);
    tick();

    // Scoreboard: reserve, resolve by write, then reserve+write collision.
    set_in(0, 0, 3, 0, 0, 0, 1, 3);
    tick();
    set_in(0, 0, 3, 0, 0, 0, 0, 0);
    #1 chk("lit_busy_pending", {31'b0, busy_2}, 32'd1);
    tick();
    set_in(0, 0, 3, 1, 3, 32'hAAAA5555, 0, 0);
    #1 chk("lit_busy_bypass", {31'b0, busy_2}, 32'd0);
    tick();
    set_in(0, 0, 3, 0, 0, 0, 0, 0);
    #1 chk("lit_busy_cleared", {31'b0, busy_2}, 32'd0);
    tick();
    set_in(0, 0, 3, 1, 3, 32'h0BADF00D, 1, 3);
    tick();
    set_in(1, 3, 3, 0, 0, 0, 0, 0);
    #1 chk("lit_set_wins", {31'b0, busy_2}, 32'd1);
    tick();
    chk("lit_set_wins_data", data_register_1, 32'h0BADF00D);

    // Mid-cycle reset clears everything immediately and discards the in-flight write.
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 0, 0, 1, AW'(i), 32'h1000_0000 + DW'(i), 0, 0);
      tick();
    end
    set_in(1, 1, 2, 0, 0, 0, 0, 0);
    tick();
    chk("lit_pre_rst_d1", data_register_1, 32'h1000_0001);
    set_in(1, 3, 4, 1, 6, 32'h66666666, 1, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_d1", data_register_1, 32'h0);
    chk("lit_rst_d2", data_register_2, 32'h0);
    chk("lit_rst_valid", {31'b0, read_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a += 2) begin
      set_in(1, AW'(a), AW'(a + 1), 0, 0, 0, 0, 0);
      tick();
      chk("lit_post_rst_d1", data_register_1, 32'h0);
      chk("lit_post_rst_d2", data_register_2, 32'h0);
    end

    // Randomized traffic with occasional resets, checked by the compare process.
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 1) == 1, rnd_addr(), rnd_addr(),
             $urandom_range(0, 2) != 0, rnd_addr(), DW'($urandom),
             $urandom_range(0, 2) == 0, rnd_addr());
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
